// File: rtl/quant_sequencer.sv
// quant_sequencer: drives one quantization job end to end.
// It scans an int32 source buffer for the peak magnitude, or skips the scan
// when the quantizer already holds a valid scale. It then requests
// calibration, streams the samples through the quantizer and writes the int8
// results to the destination buffer. A bounded drain wait sets a sticky
// timeout flag if results stop arriving.
module quant_sequencer #(
  parameter int ADDR_W        = 10,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDR_W:0]          length,
  input  logic                     reuse_scale,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err,
  output logic                     src_rd_en,
  output logic [ADDR_W-1:0]        src_rd_addr,
  input  logic signed [31:0]       src_rd_data,
  output logic                     q_start_calib,
  output logic [31:0]              q_max_abs,
  input  logic                     q_calib_ready,
  input  logic                     q_data_ready,
  output logic signed [31:0]       q_data_in,
  output logic                     q_data_valid,
  input  logic signed [7:0]        q_data_out,
  input  logic                     q_data_valid_out,
  output logic                     dst_wr_en,
  output logic [ADDR_W-1:0]        dst_wr_addr,
  output logic [7:0]               dst_wr_data
);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    CALIB_REQ,
    CALIB_WAIT,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [31:0]     DRAIN_LAST = 32'(DRAIN_TIMEOUT - 1);

  state_t          state;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] len_sat;
  logic [ADDR_W:0] rd_cnt;
  logic [ADDR_W:0] wr_cnt;
  logic [31:0]     run_max;
  logic [31:0]     raw;
  logic [31:0]     mag;
  logic [31:0]     next_max;
  logic [31:0]     drain_cnt;
  logic            scan_pend;
  logic            calib_first;

  // Length saturation, magnitude of the returning word, running-max update
  // and the pass-through of read data into the quantizer.
  always_comb begin
    len_sat   = (length > MAX_LEN) ? MAX_LEN : length;
    raw       = src_rd_data;
    mag       = raw[31] ? (~raw + 32'd1) : raw;
    next_max  = (scan_pend && (mag > run_max)) ? mag : run_max;
    q_data_in = q_data_valid ? src_rd_data : '0;
  end

  // Job FSM: state, read-side counters, calibration handshake and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      len_q         <= '0;
      rd_cnt        <= '0;
      run_max       <= '0;
      drain_cnt     <= '0;
      scan_pend     <= 1'b0;
      calib_first   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout_err   <= 1'b0;
      src_rd_en     <= 1'b0;
      src_rd_addr   <= '0;
      q_start_calib <= 1'b0;
      q_max_abs     <= '0;
      q_data_valid  <= 1'b0;
    end else begin
      done          <= 1'b0;
      q_start_calib <= 1'b0;
      // A sample reaches the quantizer one cycle after each streaming read.
      q_data_valid  <= (state == STREAM) && src_rd_en;
      case (state)
        IDLE: begin
          if (start) begin
            len_q       <= len_sat;
            timeout_err <= 1'b0;
            run_max     <= '0;
            q_max_abs   <= '0;
            scan_pend   <= 1'b0;
            busy        <= 1'b1;
            if (len_sat == '0) begin
              state <= DONE;
            end else begin
              state       <= (reuse_scale && q_data_ready) ? STREAM : SCAN;
              src_rd_en   <= 1'b1;
              src_rd_addr <= '0;
              rd_cnt      <= CNT_ONE;
            end
          end
        end
        SCAN: begin
          run_max   <= next_max;
          scan_pend <= src_rd_en;
          if (rd_cnt != len_q) begin
            src_rd_en   <= 1'b1;
            src_rd_addr <= rd_cnt[ADDR_W-1:0];
            rd_cnt      <= rd_cnt + CNT_ONE;
          end else begin
            src_rd_en <= 1'b0;
          end
          // Last word is back once a read was pending and none is in flight.
          if (scan_pend && !src_rd_en) begin
            state         <= CALIB_REQ;
            scan_pend     <= 1'b0;
            q_start_calib <= 1'b1;
            q_max_abs     <= next_max;
          end
        end
        CALIB_REQ: begin
          state       <= CALIB_WAIT;
          calib_first <= 1'b1;
        end
        CALIB_WAIT: begin
          // The ready flag may still be stale in the first cycle after the pulse.
          if (calib_first) begin
            calib_first <= 1'b0;
          end else if (q_calib_ready) begin
            state       <= STREAM;
            src_rd_en   <= 1'b1;
            src_rd_addr <= '0;
            rd_cnt      <= CNT_ONE;
          end
        end
        STREAM: begin
          if (rd_cnt != len_q) begin
            src_rd_en   <= 1'b1;
            src_rd_addr <= rd_cnt[ADDR_W-1:0];
            rd_cnt      <= rd_cnt + CNT_ONE;
          end else begin
            src_rd_en <= 1'b0;
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (wr_cnt == len_q) begin
            state <= DONE;
          end else if (drain_cnt == DRAIN_LAST) begin
            timeout_err <= 1'b1;
            state       <= DONE;
          end else begin
            drain_cnt <= drain_cnt + 32'd1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write side: commit each quantizer result to the destination buffer until the job length is reached.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt      <= '0;
      dst_wr_en   <= 1'b0;
      dst_wr_addr <= '0;
      dst_wr_data <= '0;
    end else begin
      dst_wr_en <= 1'b0;
      if (state == IDLE) begin
        wr_cnt <= '0;
      end else if (((state == STREAM) || (state == DRAIN)) && q_data_valid_out &&
                   (wr_cnt != len_q)) begin
        dst_wr_en   <= 1'b1;
        dst_wr_addr <= wr_cnt[ADDR_W-1:0];
        dst_wr_data <= q_data_out;
        wr_cnt      <= wr_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_quant_sequencer.sv
// Testbench for quant_sequencer. It provides a source memory, a fixed-latency
// quantizer model that can drop the last result, and a calibration model.
// A negedge monitor records the bus activity, and each test task compares
// that activity against expectations built from the job parameters.
module tb_quant_sequencer;
  localparam int ADDR_W = 10;
  localparam int DT     = 64;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int QLAT   = 3;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     start;
  logic [ADDR_W:0]          length;
  logic                     reuse_scale;
  logic                     busy, done, timeout_err;
  logic                     src_rd_en;
  logic [ADDR_W-1:0]        src_rd_addr;
  logic signed [31:0]       src_rd_data;
  logic                     q_start_calib;
  logic [31:0]              q_max_abs;
  logic                     q_calib_ready = 1'b0;
  logic                     q_data_ready;
  logic signed [31:0]       q_data_in;
  logic                     q_data_valid;
  logic signed [7:0]        q_data_out;
  logic                     q_data_valid_out;
  logic                     dst_wr_en;
  logic [ADDR_W-1:0]        dst_wr_addr;
  logic [7:0]               dst_wr_data;

  int passed = 0;
  int total  = 0;

  quant_sequencer #(.ADDR_W(ADDR_W), .DRAIN_TIMEOUT(DT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .length(length),
    .reuse_scale(reuse_scale), .busy(busy), .done(done), .timeout_err(timeout_err),
    .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
    .q_start_calib(q_start_calib), .q_max_abs(q_max_abs),
    .q_calib_ready(q_calib_ready), .q_data_ready(q_data_ready),
    .q_data_in(q_data_in), .q_data_valid(q_data_valid),
    .q_data_out(q_data_out), .q_data_valid_out(q_data_valid_out),
    .dst_wr_en(dst_wr_en), .dst_wr_addr(dst_wr_addr), .dst_wr_data(dst_wr_data)
  );

  always #5 clk = ~clk;

  // Source buffer: registered read, data one cycle after the request.
  logic signed [31:0] mem [DEPTH];
  always @(posedge clk) src_rd_data <= src_rd_en ? mem[src_rd_addr] : 32'sh7FFF_FFF0;

  // Quantizer model: output is the low byte of the sample after QLAT cycles.
  logic [QLAT-1:0]    vpipe;
  logic signed [7:0]  dpipe [QLAT];
  int                 smp_cnt;
  int                 exp_len = 0;
  bit                 drop_last = 1'b0;
  assign q_data_valid_out = vpipe[QLAT-1];
  assign q_data_out       = dpipe[QLAT-1];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vpipe   <= '0;
      smp_cnt <= 0;
    end else begin
      vpipe    <= {vpipe[QLAT-2:0], q_data_valid && !(drop_last && smp_cnt == exp_len - 1)};
      dpipe[0] <= q_data_in[7:0];
      for (int i = 1; i < QLAT; i++) dpipe[i] <= dpipe[i-1];
      if (start && !busy) smp_cnt <= 0;
      else if (q_data_valid) smp_cnt <= smp_cnt + 1;
    end
  end

  // Calibration model: ready rises a few cycles after each request.
  int cal_ctr = 0;
  always @(posedge clk) begin
    if (q_start_calib === 1'b1) begin
      cal_ctr       <= 3;
      q_calib_ready <= 1'b0;
    end else if (cal_ctr != 0) begin
      cal_ctr <= cal_ctr - 1;
      if (cal_ctr == 1) q_calib_ready <= 1'b1;
    end
  end

  // Monitor.
  int          rd_q[$], wr_a[$], wr_d[$];
  int          exp_rd[$], exp_wa[$], exp_wd[$];
  int          calib_cnt, done_cnt, cyc = 0, last_rd_cyc = 0, to_cyc = 0;
  logic [31:0] calib_val;
  logic        to_prev = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (src_rd_en === 1'b1) begin
      rd_q.push_back(int'(src_rd_addr));
      last_rd_cyc = cyc;
    end
    if (q_start_calib === 1'b1) begin
      calib_cnt++;
      calib_val = q_max_abs;
    end
    if (dst_wr_en === 1'b1) begin
      wr_a.push_back(int'(dst_wr_addr));
      wr_d.push_back(int'(dst_wr_data));
    end
    if (done === 1'b1) done_cnt++;
    if (timeout_err === 1'b1 && to_prev !== 1'b1) to_cyc = cyc;
    to_prev = timeout_err;
  end

  task automatic clear_mon();
    rd_q.delete(); wr_a.delete(); wr_d.delete();
    calib_cnt = 0; done_cnt = 0; calib_val = '0; to_cyc = 0;
  endtask

  // Reference model: the read sequence is an optional scan pass followed by
  // a stream pass, and destination word i holds the low byte of source word i.
  task automatic build_exp(input int n, input bit scan, input int dropped);
    logic [31:0] t;
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    if (scan) for (int i = 0; i < n; i++) exp_rd.push_back(i);
    for (int i = 0; i < n; i++) exp_rd.push_back(i);
    for (int i = 0; i < n - dropped; i++) begin
      t = mem[i];
      exp_wa.push_back(i);
      exp_wd.push_back(int'(t[7:0]));
    end
  endtask

  function automatic longint model_max(input int n);
    longint m = 0;
    longint v;
    for (int i = 0; i < n; i++) begin
      v = longint'(mem[i]);
      if (v < 0) v = -v;
      if (v > m) m = v;
    end
    return m;
  endfunction

  function automatic int diff_rd();
    int d = (rd_q.size() != exp_rd.size()) ? 1 : 0;
    for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++) if (rd_q[i] != exp_rd[i]) d++;
    return d;
  endfunction

  function automatic int diff_wr();
    int d = (wr_a.size() != exp_wa.size()) ? 1 : 0;
    for (int i = 0; i < wr_a.size() && i < exp_wa.size(); i++)
      if (wr_a[i] != exp_wa[i] || wr_d[i] != exp_wd[i]) d++;
    return d;
  endfunction

  task automatic fill_random(input int n);
    int tmp;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(1) != 0) tmp = int'($urandom);
      else tmp = int'($urandom_range(2000)) - 1000;
      mem[i] = tmp;
    end
  endtask

  task automatic do_start(input int len, input bit reuse);
    @(negedge clk);
    clear_mon();
    exp_len     = (len > DEPTH) ? DEPTH : len;
    start       = 1'b1;
    length      = 11'(len);
    reuse_scale = reuse;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; length = '0; reuse_scale = 1'b0; q_data_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, timeout_err, src_rd_en, q_start_calib, q_data_valid, dst_wr_en} !== 7'b0)
      $display("FAIL reset_strobes: got %b want 0",
               {busy, done, timeout_err, src_rd_en, q_start_calib, q_data_valid, dst_wr_en});
    else passed++;
    total++;
    if ({src_rd_addr, q_max_abs, q_data_in, dst_wr_addr, dst_wr_data} !== '0)
      $display("FAIL reset_data: got %h want 0",
               {src_rd_addr, q_max_abs, q_data_in, dst_wr_addr, dst_wr_data});
    else passed++;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else passed++;
  endtask

  task automatic test_directed();
    bit ok;
    mem[0] = 5; mem[1] = -300; mem[2] = 17; mem[3] = -2;
    q_data_ready = 1'b0;
    do_start(4, 1'b0);
    wait_done(500, ok);
    build_exp(4, 1'b1, 0);
    total++; if (!ok) $display("FAIL dir_done_timeout: got no done want done"); else passed++;
    total++; if (calib_cnt != 1) $display("FAIL dir_calib_cnt: got %0d want 1", calib_cnt); else passed++;
    total++; if (calib_val !== 32'd300) $display("FAIL dir_max: got %0d want 300", calib_val); else passed++;
    total++; if (q_max_abs !== 32'd300) $display("FAIL dir_max_hold: got %0d want 300", q_max_abs); else passed++;
    total++; if (diff_rd() != 0) $display("FAIL dir_reads: got %0d reads want %0d", rd_q.size(), exp_rd.size()); else passed++;
    total++; if (diff_wr() != 0) $display("FAIL dir_writes: got %0d writes (%0d bad) want %0d", wr_a.size(), diff_wr(), exp_wa.size()); else passed++;
    total++; if (done_cnt != 1) $display("FAIL dir_done_cnt: got %0d want 1", done_cnt); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL dir_busy_after: got %b want 0", busy); else passed++;
  endtask

  task automatic test_min_neg();
    bit ok;
    mem[0] = 100; mem[1] = 32'sh8000_0000; mem[2] = 32'sh7FFF_FFFF;
    do_start(3, 1'b0);
    wait_done(500, ok);
    build_exp(3, 1'b1, 0);
    total++; if (!ok) $display("FAIL neg_done_timeout: got no done want done"); else passed++;
    total++; if (calib_val !== 32'h8000_0000) $display("FAIL neg_max: got %h want 80000000", calib_val); else passed++;
    total++; if (diff_wr() != 0) $display("FAIL neg_writes: got %0d writes want %0d", wr_a.size(), exp_wa.size()); else passed++;
  endtask

  task automatic test_reuse();
    bit ok;
    fill_random(7);
    q_data_ready = 1'b1;
    do_start(7, 1'b1);
    total++; if (src_rd_en !== 1'b1) $display("FAIL reuse_first_rd: got %b want 1", src_rd_en); else passed++;
    wait_done(500, ok);
    q_data_ready = 1'b0;
    build_exp(7, 1'b0, 0);
    total++; if (!ok) $display("FAIL reuse_done_timeout: got no done want done"); else passed++;
    total++; if (calib_cnt != 0) $display("FAIL reuse_calib: got %0d want 0", calib_cnt); else passed++;
    total++; if (diff_rd() != 0) $display("FAIL reuse_reads: got %0d want %0d", rd_q.size(), exp_rd.size()); else passed++;
    total++; if (diff_wr() != 0) $display("FAIL reuse_writes: got %0d want %0d", wr_a.size(), exp_wa.size()); else passed++;
  endtask

  task automatic test_zero_len();
    bit ok;
    do_start(0, 1'b0);
    total++; if ({done, busy} !== 2'b01) $display("FAIL zero_cycle1: got done,busy=%b want 01", {done, busy}); else passed++;
    @(negedge clk);
    total++; if ({done, busy} !== 2'b10) $display("FAIL zero_cycle2: got done,busy=%b want 10", {done, busy}); else passed++;
    wait_done(3, ok);
    total++;
    if (rd_q.size() != 0 || wr_a.size() != 0 || calib_cnt != 0 || done_cnt != 1)
      $display("FAIL zero_activity: got rd=%0d wr=%0d cal=%0d done=%0d want 0 0 0 1",
               rd_q.size(), wr_a.size(), calib_cnt, done_cnt);
    else passed++;
  endtask

  task automatic test_timeout();
    bit ok;
    fill_random(4);
    drop_last = 1'b1;
    do_start(4, 1'b0);
    wait_done(1000, ok);
    drop_last = 1'b0;
    build_exp(4, 1'b1, 1);
    total++; if (!ok) $display("FAIL to_done_timeout: got no done want done"); else passed++;
    total++; if (timeout_err !== 1'b1) $display("FAIL to_flag: got %b want 1", timeout_err); else passed++;
    total++; if (to_cyc - last_rd_cyc != DT + 1) $display("FAIL to_delay: got %0d want %0d", to_cyc - last_rd_cyc, DT + 1); else passed++;
    total++; if (diff_wr() != 0) $display("FAIL to_writes: got %0d want %0d", wr_a.size(), exp_wa.size()); else passed++;
    total++; if (done_cnt != 1) $display("FAIL to_done_cnt: got %0d want 1", done_cnt); else passed++;
    do_start(0, 1'b0);
    total++; if (timeout_err !== 1'b0) $display("FAIL to_clear: got %b want 0", timeout_err); else passed++;
    wait_done(10, ok);
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    fill_random(16);
    do_start(16, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (q_data_valid === 1'b1) seen = 1'b1;
    end
    total++; if (!seen) $display("FAIL rst_reach_stream: got none want q_data_valid"); else passed++;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({busy, done, timeout_err, src_rd_en, src_rd_addr, q_start_calib, q_max_abs, q_data_in,
         q_data_valid, dst_wr_en, dst_wr_addr, dst_wr_data} !== '0)
      $display("FAIL rst_outputs: got %h want 0",
               {busy, done, timeout_err, src_rd_en, src_rd_addr, q_start_calib, q_max_abs, q_data_in,
                q_data_valid, dst_wr_en, dst_wr_addr, dst_wr_data});
    else passed++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    total++; if ({busy, src_rd_en, dst_wr_en} !== 3'b0) $display("FAIL rst_no_resume: got %b want 000", {busy, src_rd_en, dst_wr_en}); else passed++;
    fill_random(9);
    do_start(9, 1'b0);
    wait_done(500, ok);
    build_exp(9, 1'b1, 0);
    total++; if (!ok) $display("FAIL rst_job_done: got no done want done"); else passed++;
    total++; if (longint'(calib_val) != model_max(9)) $display("FAIL rst_job_max: got %h want %h", calib_val, model_max(9)); else passed++;
    total++; if (diff_wr() != 0 || diff_rd() != 0) $display("FAIL rst_job_traffic: got rd=%0d wr=%0d want %0d %0d", rd_q.size(), wr_a.size(), exp_rd.size(), exp_wa.size()); else passed++;
  endtask

  task automatic test_random();
    bit ok;
    int n;
    bit reuse, rdy, scan;
    for (int j = 0; j < 8; j++) begin
      n     = int'($urandom_range(24, 1));
      reuse = 1'($urandom_range(1));
      rdy   = 1'($urandom_range(1));
      scan  = !(reuse && rdy);
      fill_random(n);
      q_data_ready = rdy;
      do_start(n, reuse);
      // A second start during the job must not disturb it.
      repeat ($urandom_range(3, 1)) @(negedge clk);
      if (busy === 1'b1) begin
        start = 1'b1; length = 11'($urandom_range(60, 1)); reuse_scale = ~reuse;
        @(negedge clk);
        start = 1'b0;
      end
      wait_done(600, ok);
      build_exp(n, scan, 0);
      total++; if (!ok) $display("FAIL rnd%0d_done: got no done want done", j); else passed++;
      total++; if (calib_cnt != int'(scan)) $display("FAIL rnd%0d_calib: got %0d want %0d", j, calib_cnt, scan); else passed++;
      if (scan) begin
        total++; if (longint'(calib_val) != model_max(n)) $display("FAIL rnd%0d_max: got %h want %h", j, calib_val, model_max(n)); else passed++;
      end
      total++; if (diff_rd() != 0) $display("FAIL rnd%0d_reads: got %0d want %0d", j, rd_q.size(), exp_rd.size()); else passed++;
      total++; if (diff_wr() != 0) $display("FAIL rnd%0d_writes: got %0d want %0d", j, wr_a.size(), exp_wa.size()); else passed++;
      total++; if (done_cnt != 1 || timeout_err !== 1'b0) $display("FAIL rnd%0d_status: got done=%0d to=%b want 1 0", j, done_cnt, timeout_err); else passed++;
    end
    q_data_ready = 1'b0;
  endtask

  task automatic test_saturate();
    bit ok;
    fill_random(DEPTH);
    q_data_ready = 1'b1;
    do_start(1500, 1'b1);
    wait_done(3000, ok);
    q_data_ready = 1'b0;
    build_exp(DEPTH, 1'b0, 0);
    total++; if (!ok) $display("FAIL sat_done: got no done want done"); else passed++;
    total++; if (diff_rd() != 0) $display("FAIL sat_reads: got %0d want %0d", rd_q.size(), exp_rd.size()); else passed++;
    total++; if (diff_wr() != 0) $display("FAIL sat_writes: got %0d want %0d", wr_a.size(), exp_wa.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_min_neg();
    test_reuse();
    test_zero_len();
    test_timeout();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
